// File: rtl/veldt_mem_responder.sv
// Memory-side responder for the Veldt valid/ready bus.
// Accepts one request at a time, waits a bounded and externally steered
// number of cycles, then answers with a one-cycle mem_ready strobe.
// A small word store with byte-strobe writes backs the responses, and
// core-side protocol violations are latched in a sticky flag.
module veldt_mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WORDS  = 256,
    parameter int MIN_WAIT   = 0,
    parameter int MAX_WAIT   = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         mem_valid,
    input  logic                         mem_instr,
    input  logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic [31:0]                  mem_wdata,
    input  logic [3:0]                   mem_wstrb,
    output logic                         mem_ready,
    output logic [31:0]                  mem_rdata,
    input  logic                         stall_req,
    input  logic                         trap,
    input  logic                         init_we,
    input  logic [$clog2(MEM_WORDS)-1:0] init_addr,
    input  logic [31:0]                  init_data,
    output logic                         bus_err,
    output logic                         proto_err,
    output logic [7:0]                   wait_max_seen
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    // Counter is at least as wide as wait_max_seen so the max tracking compares cleanly.
    localparam int CNT_W = ($clog2(MAX_WAIT + 1) > 8) ? $clog2(MAX_WAIT + 1) : 8;
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_WAIT);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                state_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [31:0]           wdata_reg;
    logic [3:0]            wstrb_reg;
    logic                  instr_reg;
    logic                  ready_reg;
    logic                  bus_err_reg;
    logic                  proto_err_reg;
    logic [7:0]            wait_max_reg;

    logic [31:0]           store_mem [MEM_WORDS];
    logic [31:0]           rd_q_reg;

    logic [IDX_W-1:0]      lat_idx;
    logic                  lat_oor;
    logic                  accept;
    logic                  min_ok;
    logic                  go_resp;
    logic                  in_xfer;
    logic                  req_mismatch;
    logic                  bad_ifetch;
    logic                  proto_hit;
    logic [7:0]            cnt_sat;

    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx;
    logic [31:0]           wr_data;
    logic [3:0]            wr_be;

    // Word index ignores the byte offset; anything above the store is out of range.
    assign lat_idx = addr_reg[IDX_W+1:2];

    generate
        if (ADDR_WIDTH > IDX_W + 2) begin : g_oor
            assign lat_oor = |addr_reg[ADDR_WIDTH-1:IDX_W+2];
        end else begin : g_no_oor
            assign lat_oor = 1'b0;
        end

        if (MIN_WAIT == 0) begin : g_min_zero
            assign min_ok = 1'b1;
        end else begin : g_min_cmp
            assign min_ok = (cnt_reg >= MIN_CNT);
        end

        // wait_max_seen saturates at 255 when the counter is wider than 8 bits.
        if (CNT_W > 8) begin : g_sat
            assign cnt_sat = (cnt_reg > CNT_W'(8'hFF)) ? 8'hFF : cnt_reg[7:0];
        end else begin : g_nosat
            assign cnt_sat = cnt_reg[7:0];
        end
    endgenerate

    assign accept  = (state_reg == ST_IDLE) && mem_valid && !trap;
    // Once the counter reaches MAX_WAIT the stall request no longer holds us back.
    assign go_resp = (state_reg == ST_WAIT) && min_ok && (!stall_req || (cnt_reg == MAX_CNT));
    assign in_xfer = (state_reg == ST_WAIT) || (state_reg == ST_RESP);

    assign req_mismatch = !mem_valid || (mem_addr != addr_reg) || (mem_wdata != wdata_reg)
                        || (mem_wstrb != wstrb_reg) || (mem_instr != instr_reg);
    assign bad_ifetch   = mem_instr && (mem_wstrb != 4'b0000) && (accept || in_xfer);
    assign proto_hit    = (in_xfer && req_mismatch) || bad_ifetch;

    // Single write port: backdoor preload in IDLE, strobed bus write on the RESP edge.
    assign wr_en   = ((state_reg == ST_IDLE) && init_we) || ((state_reg == ST_RESP) && !lat_oor);
    assign wr_idx  = (state_reg == ST_IDLE) ? init_addr : lat_idx;
    assign wr_data = (state_reg == ST_IDLE) ? init_data : wdata_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_be
            assign wr_be[gi] = (state_reg == ST_IDLE) ? 1'b1 : wstrb_reg[gi];
        end
    endgenerate

    // Backing store with byte enables and a registered read of the latched index;
    // the read taken on the WAIT->RESP edge gives read-before-write data.
    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en && wr_be[b]) begin
                store_mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
        rd_q_reg <= store_mem[lat_idx];
    end

    // Request sequencing, response strobes and error/statistics tracking.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            instr_reg     <= 1'b0;
            ready_reg     <= 1'b0;
            bus_err_reg   <= 1'b0;
            proto_err_reg <= 1'b0;
            wait_max_reg  <= '0;
        end else begin
            ready_reg   <= 1'b0;
            bus_err_reg <= 1'b0;
            if (proto_hit) begin
                proto_err_reg <= 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        addr_reg  <= mem_addr;
                        wdata_reg <= mem_wdata;
                        wstrb_reg <= mem_wstrb;
                        instr_reg <= mem_instr;
                        cnt_reg   <= '0;
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (go_resp) begin
                        state_reg   <= ST_RESP;
                        ready_reg   <= 1'b1;
                        bus_err_reg <= lat_oor;
                        if (cnt_reg > CNT_W'(wait_max_reg)) begin
                            wait_max_reg <= cnt_sat;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_ready     = ready_reg;
    assign mem_rdata     = (ready_reg && !bus_err_reg) ? rd_q_reg : 32'h0000_0000;
    assign bus_err       = bus_err_reg;
    assign proto_err     = proto_err_reg;
    assign wait_max_seen = wait_max_reg;

endmodule

// File: tb/tb_veldt_mem_responder.sv
// Directed bench for veldt_mem_responder with a transaction-level model
// and a per-cycle compare process.
module tb_veldt_mem_responder;

    localparam int MIN_W = 0;
    localparam int MAX_W = 3;

    logic        clock;
    logic        reset;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall_req;
    logic        trap;
    logic        init_we;
    logic [7:0]  init_addr;
    logic [31:0] init_data;
    logic        bus_err;
    logic        proto_err;
    logic [7:0]  wait_max_seen;

    veldt_mem_responder #(
        .ADDR_WIDTH(32), .MEM_WORDS(256), .MIN_WAIT(MIN_W), .MAX_WAIT(MAX_W)
    ) dut (
        .clock(clock), .reset(reset), .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall_req(stall_req),
        .trap(trap), .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
        .bus_err(bus_err), .proto_err(proto_err), .wait_max_seen(wait_max_seen)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Model state: expected response and sticky error timing
    logic [31:0] mstore [256];
    int          exp_ready_cycle = -1;
    logic [31:0] exp_rdata = '0;
    logic        exp_berr = 1'b0;
    int          exp_w = 0;
    int          exp_proto_from = -1;
    int          exp_wms = 0;

    int          last_resp_cycle = -1;
    logic [31:0] last_rdata = '0;
    logic        last_berr = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Compare DUT outputs against the model every cycle
    always @(negedge clock) begin
        if (reset) begin
            exp_wms = 0;
            chk("reset_ready", {31'd0, mem_ready}, 32'd0);
            chk("reset_rdata", mem_rdata, 32'd0);
            chk("reset_berr", {31'd0, bus_err}, 32'd0);
            chk("reset_proto", {31'd0, proto_err}, 32'd0);
            chk("reset_wms", {24'd0, wait_max_seen}, 32'd0);
        end else begin
            if (cyc == exp_ready_cycle) begin
                if (exp_w > exp_wms) exp_wms = (exp_w > 255) ? 255 : exp_w;
                chk("ready", {31'd0, mem_ready}, 32'd1);
                chk("rdata", mem_rdata, exp_rdata);
                chk("bus_err", {31'd0, bus_err}, {31'd0, exp_berr});
            end else begin
                chk("ready_idle", {31'd0, mem_ready}, 32'd0);
                chk("rdata_idle", mem_rdata, 32'd0);
                chk("bus_err_idle", {31'd0, bus_err}, 32'd0);
            end
            chk("proto_err", {31'd0, proto_err},
                {31'd0, (exp_proto_from >= 0 && cyc >= exp_proto_from)});
            chk("wait_max_seen", {24'd0, wait_max_seen}, exp_wms);
            if (mem_ready === 1'b1) begin
                last_resp_cycle = cyc;
                last_rdata      = mem_rdata;
                last_berr       = bus_err;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        mem_valid = 1'b0;
        trap = 1'b0;
        stall_req = 1'b0;
        exp_ready_cycle = -1;
        exp_proto_from = -1;
        step();
        reset = 1'b0;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        step();
        init_we = 1'b1;
        init_addr = idx;
        init_data = data;
        mstore[idx] = data;
        step();
        init_we = 1'b0;
    endtask

    // One bus transfer. smask[k] is stall_req during wait cycle k.
    // viol: 0 none, 1 drop valid in first wait cycle, 2 change addr in first wait cycle.
    // rst_k >= 0 asserts reset during wait cycle rst_k.
    task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       input logic ins, input logic [7:0] smask, input int viol,
                       input int rst_k, input logic trap_w, input logic ie,
                       input logic [7:0] iidx, input logic [31:0] idat, output int lat);
        int c0;
        int w;
        int last_t;
        logic oor;
        logic [7:0] ix;
        step();
        last_resp_cycle = -1;
        c0 = cyc;
        mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws; mem_instr = ins;
        stall_req = 1'b0; init_we = ie; init_addr = iidx; init_data = idat;
        if (ie) mstore[iidx] = idat;
        w = MAX_W;
        for (int k = MAX_W; k >= MIN_W; k--) begin
            if (!smask[k] || k == MAX_W) w = k;
        end
        oor = (a >= 32'h400);
        ix = a[9:2];
        if (ins && ws != 4'd0 && exp_proto_from < 0) exp_proto_from = c0 + 1;
        if (rst_k < 0) begin
            exp_rdata = oor ? 32'd0 : mstore[ix];
            exp_berr = oor;
            exp_w = w;
            exp_ready_cycle = c0 + 2 + w;
            if (!oor) begin
                for (int b = 0; b < 4; b++) begin
                    if (ws[b]) mstore[ix][b*8 +: 8] = wd[b*8 +: 8];
                end
            end
        end
        last_t = (rst_k < 0) ? 3 + w : 1 + rst_k;
        for (int t = 1; t <= last_t; t++) begin
            step();
            init_we = 1'b0;
            if (t == 3 + w) begin
                mem_valid = 1'b0; mem_wstrb = 4'd0; mem_instr = 1'b0;
                stall_req = 1'b0; trap = 1'b0;
            end else begin
                if (t <= 1 + w) stall_req = smask[t-1];
                if (t == 1 && trap_w) trap = 1'b1;
                if (t == 1 && viol == 1) mem_valid = 1'b0;
                if (t == 1 && viol == 2) mem_addr = a ^ 32'h4;
                if (t == 1 && viol != 0 && exp_proto_from < 0) exp_proto_from = c0 + 2;
                if (t == 2) begin
                    mem_valid = 1'b1;
                    mem_addr = a;
                end
            end
            if (rst_k >= 0 && t == 1 + rst_k) begin
                reset = 1'b1;
                mem_valid = 1'b0; trap = 1'b0; stall_req = 1'b0;
                exp_ready_cycle = -1;
                exp_proto_from = -1;
                #1;
                chk("reset_mid_ready", {31'd0, mem_ready}, 32'd0);
                step();
                reset = 1'b0;
            end
        end
        lat = (last_resp_cycle >= 0) ? last_resp_cycle - c0 : -1;
        $display("txn addr=%h wdata=%h wstrb=%b instr=%0d lat=%0d rdata=%h bus_err=%0d proto=%0d wms=%0d",
                 a, wd, ws, ins, lat, last_rdata, last_berr, proto_err, wait_max_seen);
    endtask

    int lat;

    initial begin
        reset = 1'b1; mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0;
        mem_wstrb = '0; stall_req = 1'b0; trap = 1'b0; init_we = 1'b0; init_addr = '0;
        init_data = '0;
        repeat (3) step();
        reset = 1'b0;

        preload(8'd4, 32'h1122_3344);
        preload(8'd0, 32'hCAFE_F00D);
        preload(8'd1, 32'h0102_0304);

        // Plain read, no stall
        txn(32'h10, 32'h0, 4'h0, 1'b0, 8'h00, 0, -1, 1'b0, 1'b0, 8'd0, 32'd0, lat);
        chk("read_nostall_lat", lat, 32'd2);
        chk("read_nostall_data", last_rdata, 32'h1122_3344);
        chk("read_nostall_berr", {31'd0, last_berr}, 32'd0);

        // Strobed write then read back
        txn(32'h10, 32'hAABB_CCDD, 4'b0101, 1'b0, 8'h00, 0, -1, 1'b0, 1'b0, 8'd0, 32'd0, lat);
        chk("write_rbw_data", last_rdata, 32'h1122_3344);
        txn(32'h10, 32'h0, 4'h0, 1'b0, 8'h00, 0, -1, 1'b0, 1'b0, 8'd0, 32'd0, lat);
        chk("readback_data", last_rdata, 32'h11BB_33DD);

        // Stall held high: bounded by MAX_WAIT
        txn(32'h10, 32'h0, 4'h0, 1'b0, 8'hFF, 0, -1, 1'b0, 1'b0, 8'd0, 32'd0, lat);
        chk("stall_max_lat", lat, 32'd5);
        chk("stall_max_wms", {24'd0, wait_max_seen}, 32'd3);

        // One stall cycle, unaligned byte offset ignored
        txn(32'h13, 32'h0, 4'h0, 1'b0, 8'h01, 0, -1, 1'b0, 1'b0, 8'd0, 32'd0, lat);
        chk("stall_one_lat", lat, 32'd3);
        chk("unaligned_data", last_rdata, 32'h11BB_33DD);

        // Out of range read and write
        txn(32'h400, 32'h0, 4'h0, 1'b0, 8'h00, 0, -1, 1'b0, 1'b0, 8'd0, 32'd0, lat);
        chk("oor_berr", {31'd0, last_berr}, 32'd1);
        chk("oor_rdata", last_rdata, 32'd0);
        txn(32'h404, 32'hDEAD_BEEF, 4'hF, 1'b0, 8'h00, 0, -1, 1'b0, 1'b0, 8'd0, 32'd0, lat);
        txn(32'h0, 32'h0, 4'h0, 1'b1, 8'h00, 0, -1, 1'b0, 1'b0, 8'd0, 32'd0, lat);
        chk("after_oor_word0", last_rdata, 32'hCAFE_F00D);
        txn(32'h4, 32'h0, 4'h0, 1'b0, 8'h00, 0, -1, 1'b0, 1'b0, 8'd0, 32'd0, lat);
        chk("after_oor_word1", last_rdata, 32'h0102_0304);

        // Preload in the same cycle as request acceptance
        txn(32'h14, 32'h0, 4'h0, 1'b0, 8'h00, 0, -1, 1'b0, 1'b1, 8'd5, 32'h55AA_55AA, lat);
        chk("same_cycle_preload", last_rdata, 32'h55AA_55AA);

        // Trap raised mid-transfer: request still completes
        txn(32'h10, 32'h0, 4'h0, 1'b0, 8'h03, 0, -1, 1'b1, 1'b0, 8'd0, 32'd0, lat);
        chk("trap_wait_lat", lat, 32'd4);

        // Drop valid during WAIT: sticky proto_err
        txn(32'h10, 32'h0, 4'h0, 1'b0, 8'h01, 1, -1, 1'b0, 1'b0, 8'd0, 32'd0, lat);
        txn(32'h0, 32'h0, 4'h0, 1'b0, 8'h00, 0, -1, 1'b0, 1'b0, 8'd0, 32'd0, lat);
        chk("proto_sticky", {31'd0, proto_err}, 32'd1);

        // Reset during WAIT drops the pending write
        do_reset();
        txn(32'h10, 32'hFFFF_FFFF, 4'hF, 1'b0, 8'hFF, 0, 1, 1'b0, 1'b0, 8'd0, 32'd0, lat);
        chk("reset_mid_noresp", lat, 32'hFFFF_FFFF);
        txn(32'h10, 32'h0, 4'h0, 1'b0, 8'h00, 0, -1, 1'b0, 1'b0, 8'd0, 32'd0, lat);
        chk("reset_store_kept", last_rdata, 32'h11BB_33DD);
        chk("reset_lat", lat, 32'd2);

        // Address change during WAIT
        txn(32'h10, 32'h0, 4'h0, 1'b0, 8'h00, 2, -1, 1'b0, 1'b0, 8'd0, 32'd0, lat);
        chk("addr_change_proto", {31'd0, proto_err}, 32'd1);

        // Instruction fetch carrying write strobes
        do_reset();
        txn(32'h20, 32'h1234_5678, 4'hF, 1'b1, 8'h00, 0, -1, 1'b0, 1'b0, 8'd0, 32'd0, lat);
        chk("ifetch_wstrb_proto", {31'd0, proto_err}, 32'd1);

        // Trap in IDLE blocks acceptance
        do_reset();
        step();
        last_resp_cycle = -1;
        trap = 1'b1; mem_valid = 1'b1; mem_addr = 32'h10; mem_wstrb = 4'h0; mem_instr = 1'b0;
        repeat (6) step();
        trap = 1'b0; mem_valid = 1'b0;
        step();
        chk("trap_idle_noresp", last_resp_cycle, 32'hFFFF_FFFF);
        $display("txn trap-idle addr=00000010 resp_seen=%0d", (last_resp_cycle >= 0));

        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
